frq_decoder: RTL and testbench

//   Receive end of the divided-frequency link: measures the period of an incoming square

---
 rtl/frq_decoder_pkg.sv | 37 +++
 rtl/frq_decoder_edge_sync.sv | 23 ++
 rtl/frq_decoder.sv | 116 +++++++++++
 tb/tb_frq_decoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/frq_decoder_pkg.sv
// Shared definitions for the divided-frequency link: code width, default
// period mapping, FSM state encoding and the window-hit decode helper.
package frq_decoder_pkg;

    localparam int CODE_W          = 3;
    localparam int NUM_CODES       = 1 << CODE_W;
    localparam int PERIOD_UNIT_DEF = 16;
    localparam int TOL_DEF         = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } frq_state_t;

    // Result of matching one measured period against all code windows.
    typedef struct packed {
        logic              hit;
        logic [CODE_W-1:0] code;
    } dec_res_t;

    // Longest period that still decodes (top window upper bound).
    function automatic int max_period(input int unit, input int tol);
        return NUM_CODES * unit + tol;
    endfunction

    // Windows are disjoint, so at most one bit of h is set; report its index.
    function automatic dec_res_t hit_decode(input logic [NUM_CODES-1:0] h);
        dec_res_t r;
        r.hit  = |h;
        r.code = '0;
        for (int k = 0; k < NUM_CODES; k++) begin
            if (h[k]) r.code = CODE_W'(k);
        end
        return r;
    endfunction

endpackage

// File: rtl/frq_decoder_edge_sync.sv
// Brings the asynchronous square wave into the clk domain and turns each
// rising edge into a single-cycle pulse.
module frq_decoder_edge_sync (
    input  logic clk,
    input  logic in_sig,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    // 2-FF synchronizer followed by the edge-history register. Deliberately not
    // reset: clearing it while in_sig is high would fabricate a rising edge.
    always_ff @(posedge clk) begin
        s1   <= in_sig;
        s2   <= s1;
        prev <= s2;
    end

    assign rise = s2 & ~prev;

endmodule

// File: rtl/frq_decoder.sv
// Receive end of the divided-frequency link: measures the period between
// rising edges of in_sig, maps it onto a code window and reports the code
// once LOCK_N consecutive periods agree.
module frq_decoder
    import frq_decoder_pkg::*;
#(
    parameter int PERIOD_UNIT = PERIOD_UNIT_DEF,
    parameter int TOL         = TOL_DEF,
    parameter int CNT_W       = 8,
    parameter int LOCK_N      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_sig,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              locked,
    output logic              err,
    output logic              timeout
);

    localparam int             MAX_P = max_period(PERIOD_UNIT, TOL);
    localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_P + 1);
    localparam int             MC_W  = $clog2(LOCK_N + 1);

    logic                 rise;
    logic [CNT_W-1:0]     cnt;
    frq_state_t           state;
    logic [CODE_W-1:0]    cand;
    logic [MC_W-1:0]      match_cnt;
    logic [MC_W-1:0]      mc_inc;
    logic [MC_W-1:0]      new_mc;
    logic [NUM_CODES-1:0] hit;
    dec_res_t             dec;

    frq_decoder_edge_sync u_edge_sync (
        .clk    (clk),
        .in_sig (in_sig),
        .rise   (rise)
    );

    // Period counter: restarts at 1 on every rise so that its value at the
    // next rise equals the edge-to-edge distance; parks at MAX_P+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
        end else if (cnt != SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // One window comparator per code, bounds fixed at elaboration.
    for (genvar k = 0; k < NUM_CODES; k++) begin : g_win
        localparam logic [CNT_W-1:0] LO = CNT_W'(PERIOD_UNIT * (k + 1) - TOL);
        localparam logic [CNT_W-1:0] HI = CNT_W'(PERIOD_UNIT * (k + 1) + TOL);
        assign hit[k] = (cnt >= LO) && (cnt <= HI);
    end

    assign dec    = hit_decode(hit);
    assign mc_inc = (match_cnt == MC_W'(LOCK_N)) ? match_cnt : match_cnt + 1'b1;
    // A new candidate starts its own run at 1.
    assign new_mc = (dec.code == cand) ? mc_inc : MC_W'(1);

    // Lock FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            match_cnt <= '0;
            code      <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid   <= 1'b0;
            err     <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // First edge only opens a measurement.
                    if (rise) state <= MEASURE;
                end
                MEASURE: begin
                    if (rise) begin
                        if (!dec.hit) begin
                            err       <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                        end else begin
                            cand      <= dec.code;
                            match_cnt <= new_mc;
                            if (new_mc == MC_W'(LOCK_N)) begin
                                locked <= 1'b1;
                                code   <= dec.code;
                                valid  <= 1'b1;
                            end else begin
                                locked <= 1'b0;
                            end
                        end
                    end else if (cnt == SAT) begin
                        // Signal lost: report once and wait for a fresh edge.
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frq_decoder.sv
// Self-checking bench for frq_decoder: a period-level reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_frq_decoder;

    localparam int PU     = 16;
    localparam int TOL    = 2;
    localparam int LOCK_N = 2;
    localparam int MAX_P  = 8 * PU + TOL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_sig = 1'b0;
    logic [2:0] code;
    logic       valid, locked, err, timeout;

    int checks = 0;
    int failures = 0;

    frq_decoder #(.PERIOD_UNIT(PU), .TOL(TOL), .CNT_W(8), .LOCK_N(LOCK_N)) dut (
        .clk(clk), .rst(rst), .in_sig(in_sig), .code(code),
        .valid(valid), .locked(locked), .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         m = 0;
    int         last = 0;
    bit         armed = 0;
    bit [3:0]   smp = '0;
    int         decs[$];
    logic [2:0] m_code = '0;
    bit         m_valid = 0, m_locked = 0, m_err = 0, m_to = 0;
    bit         chk_en = 0;

    // Period -> code, or -1 when the period falls in no window.
    function automatic int decode(input int p);
        int k1;
        k1 = (p + PU / 2) / PU;
        if (k1 >= 1 && k1 <= 8 && p - PU * k1 <= TOL && PU * k1 - p <= TOL) return k1 - 1;
        return -1;
    endfunction

    function automatic bit run_locked();
        if (decs.size() < LOCK_N) return 0;
        foreach (decs[i]) if (decs[i] != decs[0]) return 0;
        return 1;
    endfunction

    // Model: a rising edge of in_sig is seen three clocks after it is sampled.
    always @(posedge clk) begin
        int p, k;
        m++;
        smp = {smp[2:0], in_sig};
        m_valid = 0; m_err = 0; m_to = 0;
        if (rst) begin
            armed = 0; m_code = '0; m_locked = 0; decs.delete();
        end else if (smp[2] && !smp[3]) begin
            if (armed) begin
                p = m - last;
                k = decode(p);
                if (k < 0) begin
                    m_err = 1; m_locked = 0; decs.delete();
                end else begin
                    decs.push_back(k);
                    if (decs.size() > LOCK_N) void'(decs.pop_front());
                    if (run_locked()) begin
                        m_locked = 1; m_code = 3'(k); m_valid = 1;
                    end else begin
                        m_locked = 0;
                    end
                end
            end
            armed = 1;
            last = m;
        end else if (armed && m - last == MAX_P + 1) begin
            m_to = 1; armed = 0; m_locked = 0; decs.delete();
        end
    end

    // Event counters and the per-cycle compare
    int cyc = 0, n_valid = 0, n_err = 0, n_to = 0, last_valid_cyc = 0, to_cyc = 0;
    always @(negedge clk) begin
        cyc++;
        if (valid) begin n_valid++; last_valid_cyc = cyc; end
        if (err) n_err++;
        if (timeout) begin n_to++; to_cyc = cyc; end
        if (chk_en) begin
            checks++;
            if ({code, valid, locked, err, timeout} !== {m_code, m_valid, m_locked, m_err, m_to}) begin
                failures++;
                $display("FAIL cycle_cmp @%0d: dut code=%0d v=%b l=%b e=%b t=%b, model code=%0d v=%b l=%b e=%b t=%b",
                         cyc, code, valid, locked, err, timeout, m_code, m_valid, m_locked, m_err, m_to);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc_drive(input bit v);
        @(negedge clk);
        in_sig = v;
    endtask

    task automatic period(input int p);
        for (int i = 0; i < p; i++) cyc_drive(i < p / 2);
    endtask

    task automatic periods(input int p, input int n);
        for (int i = 0; i < n; i++) period(p);
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) cyc_drive(1'b0);
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Move to a quiet point between edges before reading counters/outputs.
    task automatic settle_clr(input bit clr);
        @(posedge clk); #2;
        if (clr) begin n_valid = 0; n_err = 0; n_to = 0; end
    endtask

    initial begin
        int sel, k, p, n;
        repeat (4) @(negedge clk);
        chk_en = 1;
        @(negedge clk); rst = 1'b0;
        settle_clr(1);
        lit("reset_code", int'(code), 0);
        lit("reset_locked", int'(locked), 0);

        // Steady 48 and jittered periods, one bad period, relock
        periods(48, 5);
        settle_clr(0);
        lit("p48_locked", int'(locked), 1);
        lit("p48_code", int'(code), 2);
        lit("p48_valid_cnt", n_valid, 3);
        lit("p48_err_cnt", n_err, 0);
        settle_clr(1);
        period(50); period(46); period(50); period(51); periods(48, 3);
        settle_clr(0);
        lit("jit_err_cnt", n_err, 1);
        lit("jit_relock", int'(locked), 1);
        lit("jit_code", int'(code), 2);

        // Code change 2 -> 4
        periods(80, 2);
        settle_clr(0);
        lit("chg_unlocked", int'(locked), 0);
        lit("chg_code_kept", int'(code), 2);
        period(80);
        settle_clr(0);
        lit("chg_locked", int'(locked), 1);
        lit("chg_code", int'(code), 4);

        // Window boundaries
        pulse_rst();
        periods(16, 4);
        settle_clr(0);
        lit("p16_code", int'(code), 0);
        periods(128, 3);
        settle_clr(0);
        lit("p128_code", int'(code), 7);
        lit("p128_locked", int'(locked), 1);
        settle_clr(1);
        periods(13, 2); periods(24, 2);
        settle_clr(0);
        lit("bad_err_cnt", n_err, 3);
        lit("bad_code_kept", int'(code), 7);
        lit("bad_unlocked", int'(locked), 0);

        // Loss of signal
        pulse_rst();
        periods(48, 3);
        settle_clr(1);
        hold_low(200);
        settle_clr(0);
        lit("to_once", n_to, 1);
        lit("to_delay", to_cyc - last_valid_cyc, 131);
        lit("to_unlocked", int'(locked), 0);
        settle_clr(1);
        periods(48, 4);
        settle_clr(0);
        lit("to_restart_valid", n_valid, 2);
        lit("to_restart_code", int'(code), 2);

        // Reset in the middle of a period
        for (int i = 0; i < 20; i++) cyc_drive(1'b1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #2;
        lit("rst_mid_code", int'(code), 0);
        lit("rst_mid_locked", int'({valid, locked, err, timeout}), 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 26; i++) cyc_drive(i < 2);
        settle_clr(1);
        periods(48, 4);
        settle_clr(0);
        lit("rst_relock_valid", n_valid, 2);
        lit("rst_relock_code", int'(code), 2);

        // Randomized segments, checked cycle by cycle against the model
        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                k = $urandom_range(0, 7);
                n = $urandom_range(2, 5);
                for (int i = 0; i < n; i++) begin
                    p = PU * (k + 1) + $urandom_range(0, 2 * TOL) - TOL;
                    period(p);
                end
            end else if (sel < 8) begin
                period($urandom_range(10, 140));
            end else if (sel == 8) begin
                hold_low($urandom_range(100, 200));
            end else begin
                pulse_rst();
            end
        end
        hold_low(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
